athena_dip_loader: RTL and testbench

//  Bus initiator for the DIP register file: the write/read-back counterpart of the
//  DIP responder.
//  - On a start pulse, writes a per-game default DIP table over bus_if: 16 byte

---
 rtl/athena_pkg.sv | 97 +++++++++
 rtl/bus_if.sv | 29 ++
 rtl/athena_dip_loader.sv | 147 ++++++++++++++
 tb/tb_athena_dip_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/athena_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : athena (package)
//  Description : Shared types and helpers for the Athena DIP register file.
//                Holds the game code enum, the DIP loader state enum, the
//                register stride and the per-game default DIP table.
//  Revision    : 1.0  initial release
// ============================================================================
package athena;

    // Game codes as written into DIP entry 15.
    typedef enum logic [7:0] {
        game_athena        = 8'h00,
        game_fighting_golf = 8'h01
    } game_e;

    // DIP loader sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAIL  = 3'd5
    } loader_state_e;

    localparam int DIP_ENTRY_STRIDE = 4;   // bytes between consecutive entries
    localparam int DIP_NUM_ENTRIES  = 16;
    localparam int DIP_IDX_W        = 4;
    localparam logic [DIP_IDX_W-1:0] DIP_GAME_IDX = 4'd15;

    // Encoded switch defaults, same indices the DIP responder decodes.
    // Athena (entries 0..7)
    localparam logic [7:0] C_ATH_LIVES      = 8'h02;  // 3 lives
    localparam logic [7:0] C_ATH_DIFFICULTY = 8'h01;  // normal
    localparam logic [7:0] C_ATH_BONUS      = 8'h03;  // 50k/100k
    localparam logic [7:0] C_ATH_COIN_A     = 8'h00;  // 1 coin 1 credit
    localparam logic [7:0] C_ATH_COIN_B     = 8'h00;  // 1 coin 1 credit
    localparam logic [7:0] C_ATH_DEMO_SND   = 8'h01;  // on
    localparam logic [7:0] C_ATH_FLIP       = 8'h00;  // off
    localparam logic [7:0] C_ATH_CABINET    = 8'h01;  // upright
    // Fighting Golf (entries 0..11)
    localparam logic [7:0] C_FG_HOLES       = 8'h01;
    localparam logic [7:0] C_FG_DIFFICULTY  = 8'h02;
    localparam logic [7:0] C_FG_TIME        = 8'h00;
    localparam logic [7:0] C_FG_COIN_A      = 8'h03;
    localparam logic [7:0] C_FG_COIN_B      = 8'h01;
    localparam logic [7:0] C_FG_FLIP        = 8'h00;
    localparam logic [7:0] C_FG_DEMO_SND    = 8'h01;
    localparam logic [7:0] C_FG_CONTINUE    = 8'h02;
    localparam logic [7:0] C_FG_CABINET     = 8'h01;
    localparam logic [7:0] C_FG_FREEPLAY    = 8'h00;
    localparam logic [7:0] C_FG_PLAYERS     = 8'h01;
    localparam logic [7:0] C_FG_BONUS       = 8'h03;

    // Default byte for one DIP entry. Entry 15 always carries the raw game
    // code, so an unrecognised code still reaches the responder verbatim
    // while the switch entries fall back to the Athena map.
    function automatic logic [7:0] dip_default(game_e game, logic [3:0] idx);
        logic [7:0] v;
        v = 8'h00;
        if (idx == DIP_GAME_IDX) begin
            v = game;
        end else if (game == game_fighting_golf) begin
            case (idx)
                4'd0:    v = C_FG_HOLES;
                4'd1:    v = C_FG_DIFFICULTY;
                4'd2:    v = C_FG_TIME;
                4'd3:    v = C_FG_COIN_A;
                4'd4:    v = C_FG_COIN_B;
                4'd5:    v = C_FG_FLIP;
                4'd6:    v = C_FG_DEMO_SND;
                4'd7:    v = C_FG_CONTINUE;
                4'd8:    v = C_FG_CABINET;
                4'd9:    v = C_FG_FREEPLAY;
                4'd10:   v = C_FG_PLAYERS;
                4'd11:   v = C_FG_BONUS;
                default: v = 8'h00;
            endcase
        end else begin
            case (idx)
                4'd0:    v = C_ATH_LIVES;
                4'd1:    v = C_ATH_DIFFICULTY;
                4'd2:    v = C_ATH_BONUS;
                4'd3:    v = C_ATH_COIN_A;
                4'd4:    v = C_ATH_COIN_B;
                4'd5:    v = C_ATH_DEMO_SND;
                4'd6:    v = C_ATH_FLIP;
                4'd7:    v = C_ATH_CABINET;
                default: v = 8'h00;
            endcase
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_if
//  Description : Simple single-clock register bus. One write per cycle with
//                no wait states; reads return rd_data with rd_data_valid some
//                cycles after a one-cycle rd pulse. Runs on the initiator's clk.
//  Ports       : addr, wr, wr_data, rd       initiator -> responder
//                rd_data, rd_data_valid      responder -> initiator
//  Revision    : 1.0  initial release
// ============================================================================
interface bus_if;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wr_data;
    logic        rd;
    logic [31:0] rd_data;
    logic        rd_data_valid;

    modport initiator (
        output addr, wr, wr_data, rd,
        input  rd_data, rd_data_valid
    );

    modport responder (
        input  addr, wr, wr_data, rd,
        output rd_data, rd_data_valid
    );
endinterface
`default_nettype wire

// File: rtl/athena_dip_loader.sv
`default_nettype none
// ============================================================================
//  Module      : athena_dip_loader
//  Description : Bus initiator that loads the per-game default DIP table into
//                the DIP register file and then reads every entry back to
//                verify the low byte.
//  Ports       : clk          clock (bus_if runs on it)
//                reset        asynchronous, active-high
//                start        pulse; begins load+verify, ignored while busy
//                game         default table select, sampled on accepted start
//                bridge       bus_if initiator side
//                busy         high from accepted start until DONE/FAIL
//                done         sticky pass flag, cleared by next accepted start
//                error        sticky mismatch/timeout flag, cleared likewise
//                error_index  first failing entry, valid while error=1
//  Revision    : 1.0  initial release
// ============================================================================
module athena_dip_loader
    import athena::*;
#(
    parameter int          NUM_ENTRIES = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          TIMEOUT     = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  game_e           game,
    bus_if.initiator        bridge,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [3:0]      error_index
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [DIP_IDX_W-1:0] C_LAST_IDX = DIP_IDX_W'(NUM_ENTRIES - 1);
    // WAIT lasts at most TIMEOUT cycles, so the FAIL decision lands on the
    // TIMEOUT-th clock edge after the edge that sampled rd.
    localparam logic [TMR_W-1:0]     C_TMR_LAST = TMR_W'(TIMEOUT - 1);

    loader_state_e          r_state;
    logic [DIP_IDX_W-1:0]   r_idx;
    game_e                  r_game;
    logic [TMR_W-1:0]       r_timer;
    logic                   r_done;
    logic                   r_error;
    logic [DIP_IDX_W-1:0]   r_err_idx;

    logic [7:0]             w_expect;
    logic                   w_rd_match;
    logic                   w_last;
    logic                   w_idle_like;
    logic                   w_unused_rd_hi;

    assign w_expect    = dip_default(r_game, r_idx);
    assign w_rd_match  = (bridge.rd_data[7:0] == w_expect);
    assign w_last      = (r_idx == C_LAST_IDX);
    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE) ||
                         (r_state == ST_FAIL);
    // Upper read-back bits are not part of the comparison.
    assign w_unused_rd_hi = ^bridge.rd_data[31:8];

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_game    <= game_athena;
            r_timer   <= '0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_err_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (start) begin
                        r_game    <= game;
                        r_done    <= 1'b0;
                        r_error   <= 1'b0;
                        r_err_idx <= '0;
                        r_idx     <= '0;
                        r_state   <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    if (w_last) begin
                        r_idx   <= '0;
                        r_state <= ST_READ;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                    end
                end

                ST_READ: begin
                    r_timer <= '0;
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (bridge.rd_data_valid) begin
                        if (!w_rd_match) begin
                            r_error   <= 1'b1;
                            r_err_idx <= r_idx;
                            r_state   <= ST_FAIL;
                        end else if (w_last) begin
                            r_done    <= 1'b1;
                            r_state   <= ST_DONE;
                        end else begin
                            r_idx     <= r_idx + 1'b1;
                            r_state   <= ST_READ;
                        end
                    end else if (r_timer == C_TMR_LAST) begin
                        r_error   <= 1'b1;
                        r_err_idx <= r_idx;
                        r_state   <= ST_FAIL;
                    end else begin
                        r_timer   <= r_timer + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Bus drive: decoded from state so wr and rd are mutually exclusive and
    // fall together with reset without waiting for a clock.
    // ------------------------------------------------------------------------
    assign bridge.wr      = (r_state == ST_WRITE);
    assign bridge.rd      = (r_state == ST_READ);
    assign bridge.addr    = BASE_ADDR + (32'(r_idx) * 32'(DIP_ENTRY_STRIDE));
    assign bridge.wr_data = (r_state == ST_WRITE) ? {24'b0, w_expect} : 32'b0;

    assign busy        = !w_idle_like;
    assign done        = r_done;
    assign error       = r_error;
    assign error_index = r_err_idx;

endmodule
`default_nettype wire

// File: tb/tb_athena_dip_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_athena_dip_loader
//  Description : Directed bench for athena_dip_loader with a zero-wait DIP
//                responder that can corrupt or drop a chosen read-back.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_athena_dip_loader;
    import athena::*;

    localparam int TIMEOUT = 15;

    logic       clk;
    logic       reset;
    logic       start;
    game_e      game;
    logic       busy;
    logic       done;
    logic       error;
    logic [3:0] error_index;

    bus_if bus ();

    athena_dip_loader #(
        .NUM_ENTRIES (16),
        .BASE_ADDR   (32'h0000_0000),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .game        (game),
        .bridge      (bus),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .error_index (error_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Responder model
    // ------------------------------------------------------------------------
    logic [31:0] mem [16];
    logic [31:0] wr_addr_log [256];
    logic [31:0] wr_data_log [256];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          overlap_cnt = 0;
    logic        corrupt_en = 1'b0;
    logic [3:0]  corrupt_idx = 4'd0;
    logic        drop_en = 1'b0;
    logic [3:0]  drop_idx = 4'd0;

    always @(posedge clk) begin
        bus.rd_data_valid <= 1'b0;
        if (bus.wr) begin
            mem[bus.addr[5:2]]      <= bus.wr_data;
            wr_addr_log[wr_cnt % 256] <= bus.addr;
            wr_data_log[wr_cnt % 256] <= bus.wr_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.rd) begin
            rd_cnt <= rd_cnt + 1;
            if (!(drop_en && bus.addr[5:2] == drop_idx)) begin
                bus.rd_data_valid <= 1'b1;
                bus.rd_data <= mem[bus.addr[5:2]] ^
                               {31'b0, (corrupt_en && bus.addr[5:2] == corrupt_idx)};
            end
        end
        if (bus.wr && bus.rd)
            overlap_cnt <= overlap_cnt + 1;
    end

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Hand-written default tables.
    function automatic logic [7:0] exp_entry(input logic [7:0] g, input int i);
        logic [7:0] v;
        v = 8'h00;
        if (i == 15) begin
            v = g;
        end else if (g == 8'h01) begin
            case (i)
                0: v = 8'h01;  1: v = 8'h02;  2: v = 8'h00;  3: v = 8'h03;
                4: v = 8'h01;  5: v = 8'h00;  6: v = 8'h01;  7: v = 8'h02;
                8: v = 8'h01;  9: v = 8'h00; 10: v = 8'h01; 11: v = 8'h03;
                default: v = 8'h00;
            endcase
        end else begin
            case (i)
                0: v = 8'h02;  1: v = 8'h01;  2: v = 8'h03;  3: v = 8'h00;
                4: v = 8'h00;  5: v = 8'h01;  6: v = 8'h00;  7: v = 8'h01;
                default: v = 8'h00;
            endcase
        end
        return v;
    endfunction

    logic busy1;
    logic done1;

    // Caller sits just after a negedge. Pulses start, then counts cycles
    // (negedge samples) until done/error, stop_at, or the budget runs out.
    // Cycle 1 is the cycle right after the edge that accepts start.
    task automatic run(input logic [7:0] g, input int restart_at,
                       input logic [7:0] g2, input int stop_at, output int n);
        logic ended;
        ended = 1'b0;
        n     = 0;
        game  = game_e'(g);
        start = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            n++;
            start = (n == restart_at);
            if (n == restart_at) game = game_e'(g2);
            if (n == 1) begin
                busy1 = busy;
                done1 = done;
            end
            if (done || error || n == stop_at) begin
                ended = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!ended) check_val("run_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_writes(input int base, input logic [7:0] g,
                                input string tag);
        check_val({tag, "_wr_count"}, 32'(wr_cnt - base), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check_val({tag, "_wr_addr"}, wr_addr_log[(base + i) % 256], 32'(4 * i));
            check_val({tag, "_wr_data"}, wr_data_log[(base + i) % 256],
                      {24'b0, exp_entry(g, i)});
        end
    endtask

    int n;
    int wbase;
    int rbase;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        game  = game_athena;
        repeat (3) @(negedge clk);

        // Reset state
        check_val("rst_wr",      32'(bus.wr),      32'd0);
        check_val("rst_rd",      32'(bus.rd),      32'd0);
        check_val("rst_addr",    bus.addr,         32'd0);
        check_val("rst_wr_data", bus.wr_data,      32'd0);
        check_val("rst_busy",    32'(busy),        32'd0);
        check_val("rst_done",    32'(done),        32'd0);
        check_val("rst_error",   32'(error),       32'd0);
        check_val("rst_err_idx", 32'(error_index), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1. Athena table, zero-wait responder: done in cycle 49
        wbase = wr_cnt;
        run(8'h00, -1, 8'h00, -1, n);
        check_val("t1_done_cycle", 32'(n), 32'd49);
        check_val("t1_done",  32'(done),  32'd1);
        check_val("t1_error", 32'(error), 32'd0);
        check_val("t1_busy",  32'(busy),  32'd0);
        check_val("t1_busy_c1", 32'(busy1), 32'd1);
        check_writes(wbase, 8'h00, "t1");

        // 2. Fighting Golf table; start from DONE clears done at once
        wbase = wr_cnt;
        run(8'h01, -1, 8'h01, -1, n);
        check_val("t2_done_clr", 32'(done1), 32'd0);
        check_val("t2_done_cycle", 32'(n), 32'd49);
        check_val("t2_done", 32'(done), 32'd1);
        check_writes(wbase, 8'h01, "t2");
        check_val("t2_mem11", mem[11], 32'h03);
        check_val("t2_mem15", mem[15], 32'h01);

        // 3. Entry 5 read-back bit0 flipped: FAIL right after its WAIT
        corrupt_en = 1'b1; corrupt_idx = 4'd5;
        rbase = rd_cnt;
        run(8'h00, -1, 8'h00, -1, n);
        check_val("t3_fail_cycle", 32'(n), 32'd29);
        check_val("t3_error",   32'(error),       32'd1);
        check_val("t3_err_idx", 32'(error_index), 32'd5);
        check_val("t3_done",    32'(done),        32'd0);
        repeat (10) @(negedge clk);
        check_val("t3_rd_count", 32'(rd_cnt - rbase), 32'd6);
        check_val("t3_busy", 32'(busy), 32'd0);
        corrupt_en = 1'b0;

        // 4. Entry 3 never answered: rd in cycle 23, WAIT for TIMEOUT cycles,
        //    error visible from cycle 23 + TIMEOUT + 1.
        drop_en = 1'b1; drop_idx = 4'd3;
        rbase = rd_cnt;
        run(8'h00, -1, 8'h00, -1, n);
        check_val("t4_fail_cycle", 32'(n), 32'(23 + TIMEOUT + 1));
        check_val("t4_error",   32'(error),       32'd1);
        check_val("t4_err_idx", 32'(error_index), 32'd3);
        check_val("t4_done",    32'(done),        32'd0);
        repeat (10) @(negedge clk);
        check_val("t4_rd_count", 32'(rd_cnt - rbase), 32'd4);
        drop_en = 1'b0;

        // 5. start (with another game) during WRITE of entry 7 is ignored
        wbase = wr_cnt;
        run(8'h00, 8, 8'h01, -1, n);
        check_val("t5_err_clr", 32'(error), 32'd0);
        check_val("t5_done_cycle", 32'(n), 32'd49);
        check_val("t5_done", 32'(done), 32'd1);
        repeat (5) @(negedge clk);
        check_writes(wbase, 8'h00, "t5");
        //    later start from DONE reruns
        run(8'h01, -1, 8'h01, -1, n);
        check_val("t5_rerun_done_clr", 32'(done1), 32'd0);
        check_val("t5_rerun_cycle", 32'(n), 32'd49);
        check_val("t5_rerun_done", 32'(done), 32'd1);

        // 6. Reset while writing entry 9 (cycle 10)
        wbase = wr_cnt;
        run(8'h00, -1, 8'h00, 10, n);
        check_val("t6_pre_wr", 32'(bus.wr), 32'd1);
        reset = 1'b1;
        #1;
        check_val("t6_wr",   32'(bus.wr), 32'd0);
        check_val("t6_rd",   32'(bus.rd), 32'd0);
        check_val("t6_busy", 32'(busy),   32'd0);
        check_val("t6_done", 32'(done),   32'd0);
        check_val("t6_addr", bus.addr,    32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_val("t6_idle_busy", 32'(busy), 32'd0);
        check_val("t6_partial_writes", 32'(wr_cnt - wbase), 32'd9);
        run(8'h00, -1, 8'h00, -1, n);
        check_val("t6_rerun_cycle", 32'(n), 32'd49);
        check_val("t6_rerun_done", 32'(done), 32'd1);

        // 7. Unknown game code: Athena switches, raw code in entry 15
        wbase = wr_cnt;
        run(8'h07, -1, 8'h07, -1, n);
        check_val("t7_done", 32'(done), 32'd1);
        check_val("t7_entry0",  wr_data_log[(wbase + 0) % 256],  32'h02);
        check_val("t7_entry15", wr_data_log[(wbase + 15) % 256], 32'h07);

        check_val("wr_rd_overlap", 32'(overlap_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
